// File: rtl/ccg_signature_engine_pkg.sv
// Shared types and helpers for the CCG signature engine and its MISR.
package ccg_sig_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [31:0] POLY_DEFAULT = 32'h04C1_1DB7;

  // One MISR shift of a w-bit register (w <= 32); bits above w are forced to 0.
  function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] poly,
                                            input logic [31:0] din, input int w);
    logic [31:0] mask;
    logic [31:0] r;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    r    = (sig << 1) ^ (sig[5'(w - 1)] ? poly : 32'd0) ^ din;
    return r & mask;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/ccg_signature_engine_if.sv
// Control/result bus between the dataset-labelling controller and the signature engine.
interface ccg_sig_if #(
  parameter int N_OUT = 5,
  parameter int SIG_W = 32,
  parameter int CNT_W = 16
) ();
  logic                   start_i;
  logic                   mode_i;
  logic [CNT_W-1:0]       count_i;
  logic [31:0]            seed_i;
  logic                   busy_o;
  logic                   done_o;
  logic [SIG_W-1:0]       signature_o;
  logic [N_OUT*CNT_W-1:0] ones_o;

  modport slave  (input start_i, mode_i, count_i, seed_i,
                  output busy_o, done_o, signature_o, ones_o);
  modport master (output start_i, mode_i, count_i, seed_i,
                  input busy_o, done_o, signature_o, ones_o);
endinterface

// File: rtl/ccg_signature_engine_misr.sv
// Multiple-input signature register with synchronous clear (priority) and enable.
module ccg_misr import ccg_sig_pkg::*; #(
  parameter int          SIG_W = 32,
  parameter logic [31:0] POLY  = POLY_DEFAULT,
  parameter int          DIN_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIN_W-1:0] din_i,
  output logic [SIG_W-1:0] sig_o
);
  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr_i)     sig_d = '0;
    else if (en_i) sig_d = SIG_W'(misr_step(32'(sig_q), POLY, 32'(din_i), SIG_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign sig_o = sig_q;
endmodule

// File: rtl/ccg_signature_engine.sv
// Drives exhaustive or LFSR patterns into a (possibly pipelined) CUT and compacts its outputs.
//   state   | meaning
//   IDLE    | waiting for start; results held on the outputs
//   DRIVE   | one pattern per cycle, P cycles
//   DRAIN   | CUT_LAT cycles for in-flight CUT results
//   DONE    | one-cycle completion pulse, results presented
module ccg_signature_engine import ccg_sig_pkg::*; #(
  parameter int          N_IN    = 5,
  parameter int          N_OUT   = 5,
  parameter int          CUT_LAT = 0,
  parameter int          SIG_W   = 32,
  parameter logic [31:0] POLY    = POLY_DEFAULT,
  parameter int          CNT_W   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  ccg_sig_if.slave        bus,
  output logic [N_IN-1:0] x_o,
  input  logic [N_OUT-1:0] f_i
);
  localparam int               REM_W     = (N_IN + 1 > CNT_W) ? N_IN + 1 : CNT_W;
  localparam logic [REM_W-1:0] P_EXH     = REM_W'(1) << N_IN;
  localparam logic [3:0]       DRAIN_LEN = 4'(CUT_LAT);
  localparam logic [CNT_W-1:0] ONES_MAX  = '1;

  state_e           state_q, state_d;
  logic             accept, drive, sample;
  logic             mode_q, mode_d;
  logic [REM_W-1:0] rem_q, rem_d, p_req;
  logic [3:0]       drn_q, drn_d;
  logic [31:0]      lfsr_q, lfsr_d, seed_eff;
  logic [N_IN-1:0]  x_q, x_d;
  logic [CNT_W-1:0] ones_q [N_OUT];
  logic [CNT_W-1:0] ones_d [N_OUT];
  logic [CNT_W-1:0] ones_out_q [N_OUT];
  logic [SIG_W-1:0] sig_cur, sig_out_q;

  assign p_req    = bus.mode_i ? REM_W'(bus.count_i) : P_EXH;
  assign seed_eff = (bus.seed_i == 32'd0) ? 32'd1 : bus.seed_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start_i) state_d = (p_req == '0) ? S_DONE : S_DRIVE;
      S_DRIVE: if (rem_q == REM_W'(1)) state_d = (CUT_LAT == 0) ? S_DONE : S_DRAIN;
      S_DRAIN: if (drn_q == 4'd1) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Results are shown live from the compaction registers during DONE, then held.
  always_comb begin
    accept          = (state_q == S_IDLE) && bus.start_i;
    drive           = (state_q == S_DRIVE);
    bus.busy_o      = (state_q == S_DRIVE) || (state_q == S_DRAIN);
    bus.done_o      = (state_q == S_DONE);
    bus.signature_o = (state_q == S_DONE) ? sig_cur : sig_out_q;
    bus.ones_o      = '0;
    for (int j = 0; j < N_OUT; j++)
      bus.ones_o[j*CNT_W +: CNT_W] = (state_q == S_DONE) ? ones_q[j] : ones_out_q[j];
  end

  always_comb begin
    mode_d = mode_q;
    rem_d  = rem_q;
    drn_d  = drn_q;
    lfsr_d = lfsr_q;
    x_d    = x_q;
    if (accept) begin
      mode_d = bus.mode_i;
      rem_d  = p_req;
      lfsr_d = seed_eff;
      if (p_req != '0) x_d = bus.mode_i ? seed_eff[N_IN-1:0] : '0;
    end else if (drive) begin
      rem_d = rem_q - REM_W'(1);
      drn_d = DRAIN_LEN;
      if (rem_q != REM_W'(1)) begin
        lfsr_d = lfsr_step(lfsr_q);
        x_d    = mode_q ? lfsr_d[N_IN-1:0] : x_q + N_IN'(1);
      end
    end else if (state_q == S_DRAIN) begin
      drn_d = drn_q - 4'd1;
    end
  end

  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      ones_d[j] = ones_q[j];
      if (accept) ones_d[j] = '0;
      else if (sample && f_i[j] && (ones_q[j] != ONES_MAX)) ones_d[j] = ones_q[j] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 1'b0;
      rem_q     <= '0;
      drn_q     <= '0;
      lfsr_q    <= 32'd1;
      x_q       <= '0;
      sig_out_q <= '0;
      for (int j = 0; j < N_OUT; j++) begin
        ones_q[j]     <= '0;
        ones_out_q[j] <= '0;
      end
    end else begin
      mode_q <= mode_d;
      rem_q  <= rem_d;
      drn_q  <= drn_d;
      lfsr_q <= lfsr_d;
      x_q    <= x_d;
      for (int j = 0; j < N_OUT; j++) ones_q[j] <= ones_d[j];
      if (state_q == S_DONE) begin
        sig_out_q <= sig_cur;
        for (int j = 0; j < N_OUT; j++) ones_out_q[j] <= ones_q[j];
      end
    end
  end

  // Tag pipe: the CUT output for a pattern is valid when its tag reaches the last stage.
  generate
    if (CUT_LAT == 0) begin : g_comb_cut
      assign sample = drive;
    end else begin : g_pipe_cut
      logic [CUT_LAT-1:0] vld_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      vld_q <= '0;
        else if (accept) vld_q <= '0;
        else             vld_q <= (vld_q << 1) | CUT_LAT'(drive);
      end
      assign sample = vld_q[CUT_LAT-1];
    end
  endgenerate

  ccg_misr #(.SIG_W(SIG_W), .POLY(POLY), .DIN_W(N_OUT)) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (accept),
    .en_i  (sample),
    .din_i (f_i),
    .sig_o (sig_cur)
  );

  assign x_o = x_q;
endmodule

// File: tb/tb_ccg_signature_engine.sv
// Scoreboard bench: three engine configurations, expectations queued at stimulus, checked on done_o.
module tb_ccg_signature_engine;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef struct {
    logic [31:0] sig;
    logic [79:0] ones;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t q0[$], q1[$], q2[$];
  int bc[3] = '{0, 0, 0};
  int nd[3] = '{0, 0, 0};
  int gap = 0;
  bit have_done = 1'b0;
  bit chk_gap = 1'b0;
  int cut_a = 0;

  logic [4:0] x_a, f_a, x_b, f_b, x_c, f_c;
  logic [4:0] r1 = '0, r2 = '0, r3 = '0;

  ccg_sig_if #(.N_OUT(5), .SIG_W(32), .CNT_W(16)) ia ();
  ccg_sig_if #(.N_OUT(5), .SIG_W(32), .CNT_W(16)) ib ();
  ccg_sig_if #(.N_OUT(5), .SIG_W(32), .CNT_W(4))  ic ();

  ccg_signature_engine #(.N_IN(5), .N_OUT(5), .CUT_LAT(0), .SIG_W(32), .POLY(POLY), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia), .x_o(x_a), .f_i(f_a));
  ccg_signature_engine #(.N_IN(5), .N_OUT(5), .CUT_LAT(3), .SIG_W(32), .POLY(POLY), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib), .x_o(x_b), .f_i(f_b));
  ccg_signature_engine #(.N_IN(5), .N_OUT(5), .CUT_LAT(0), .SIG_W(32), .POLY(POLY), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ic), .x_o(x_c), .f_i(f_c));

  // CUTs: selectable combinational for A, 3-stage registered identity for B, constant ones for C.
  assign f_a = (cut_a == 0) ? x_a : (cut_a == 1) ? 5'd0 : 5'h1f;
  always @(posedge clk) begin
    r1 <= x_b;
    r2 <= r1;
    r3 <= r2;
  end
  assign f_b = r3;
  assign f_c = 5'h1f;

  function automatic exp_t model(input bit mode, input int cnt, input logic [31:0] seed,
                                 input int cut, input int cntw, input int lat);
    exp_t r;
    logic [31:0] s;
    logic [4:0] x, f;
    int n, mx;
    int one[5];
    s = (seed == 32'd0) ? 32'd1 : seed;
    n = mode ? cnt : 32;
    mx = (1 << cntw) - 1;
    r.sig = '0;
    r.ones = '0;
    for (int j = 0; j < 5; j++) one[j] = 0;
    for (int k = 0; k < n; k++) begin
      x = mode ? s[4:0] : k[4:0];
      f = (cut == 0) ? x : (cut == 1) ? 5'd0 : 5'h1f;
      r.sig = {r.sig[30:0], 1'b0} ^ (r.sig[31] ? POLY : 32'd0) ^ {27'd0, f};
      for (int j = 0; j < 5; j++) if (f[j] && one[j] < mx) one[j]++;
      if (mode) s = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    end
    for (int j = 0; j < 5; j++) r.ones[j*16 +: 16] = 16'(one[j]);
    r.lat = n + lat + 1;
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, req);
    end
  endtask

  task automatic finish_run(input string who, input int qn, input exp_t e, input logic [31:0] sig,
                            input logic [79:0] ones, input logic [79:0] mask, input int lat);
    if (qn == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_done actual 1 required 0", who);
    end else begin
      cmp({who, "_signature"}, 80'(sig), 80'(e.sig));
      cmp({who, "_ones"}, ones & mask, e.ones & mask);
      cmp({who, "_latency"}, 80'(lat), 80'(e.lat));
    end
  endtask

  always @(negedge clk) begin : mon_a
    int n;
    exp_t e;
    if (ia.done_o) begin
      n = q0.size();
      if (n != 0) e = q0.pop_front();
      finish_run("a", n, e, ia.signature_o, 80'(ia.ones_o), '1, bc[0] + 1);
      bc[0] = 0;
      nd[0]++;
      gap = 0;
      have_done = chk_gap;
    end else if (ia.busy_o) begin
      if (bc[0] == 0 && chk_gap && have_done) cmp("a_idle_gap", 80'(gap), 80'd1);
      bc[0]++;
    end else begin
      bc[0] = 0;
      gap++;
    end
  end

  always @(negedge clk) begin : mon_b
    int n;
    exp_t e;
    if (ib.done_o) begin
      n = q1.size();
      if (n != 0) e = q1.pop_front();
      finish_run("b", n, e, ib.signature_o, 80'(ib.ones_o), '1, bc[1] + 1);
      bc[1] = 0;
      nd[1]++;
    end else if (ib.busy_o) bc[1]++;
    else bc[1] = 0;
  end

  always @(negedge clk) begin : mon_c
    int n;
    exp_t e;
    if (ic.done_o) begin
      n = q2.size();
      if (n != 0) e = q2.pop_front();
      finish_run("c", n, e, ic.signature_o, 80'(ic.ones_o), 80'hF_FFFF, bc[2] + 1);
      bc[2] = 0;
      nd[2]++;
    end else if (ic.busy_o) bc[2]++;
    else bc[2] = 0;
  end

  task automatic go(input int d, input bit mode, input int cnt, input logic [31:0] seed);
    int n0;
    n0 = nd[d];
    @(negedge clk);
    case (d)
      0: begin ia.mode_i = mode; ia.count_i = 16'(cnt); ia.seed_i = seed; ia.start_i = 1'b1; end
      1: begin ib.mode_i = mode; ib.count_i = 16'(cnt); ib.seed_i = seed; ib.start_i = 1'b1; end
      default: begin ic.mode_i = mode; ic.count_i = 4'(cnt); ic.seed_i = seed; ic.start_i = 1'b1; end
    endcase
    @(negedge clk);
    ia.start_i = 1'b0;
    ib.start_i = 1'b0;
    ic.start_i = 1'b0;
    for (int i = 0; i < 2000 && nd[d] == n0; i++) @(negedge clk);
    if (nd[d] == n0) begin
      checks++;
      errors++;
      $display("FAIL run_timeout dut %0d actual no_done required done", d);
    end
  endtask

  initial begin
    exp_t e_id, e;
    int k;
    ia.start_i = 0; ia.mode_i = 0; ia.count_i = '0; ia.seed_i = '0;
    ib.start_i = 0; ib.mode_i = 0; ib.count_i = '0; ib.seed_i = '0;
    ic.start_i = 0; ic.mode_i = 0; ic.count_i = '0; ic.seed_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmp("reset_signature", 80'(ia.signature_o), 80'd0);
    cmp("reset_ones", 80'(ia.ones_o), 80'd0);
    cmp("reset_busy", 80'(ia.busy_o), 80'd0);
    cmp("reset_done", 80'(ia.done_o), 80'd0);
    cmp("reset_x", 80'(x_a), 80'd0);

    // Exhaustive, identity CUT: 32 patterns, each output bit set in 16 of them.
    e_id = model(1'b0, 0, 32'd0, 0, 16, 0);
    e_id.ones = {5{16'd16}};
    e_id.lat = 33;
    q0.push_back(e_id);
    go(0, 1'b0, 0, 32'd0);

    cut_a = 1;
    e.sig = 32'd0; e.ones = '0; e.lat = 33;
    q0.push_back(e);
    go(0, 1'b0, 0, 32'd0);

    cut_a = 2;
    e = model(1'b0, 0, 32'd0, 2, 16, 0);
    e.ones = {5{16'd32}};
    q0.push_back(e);
    go(0, 1'b0, 0, 32'd0);
    cut_a = 0;

    // Seed 0 must behave as seed 1.
    e = model(1'b1, 20, 32'd1, 0, 16, 0);
    q0.push_back(e);
    q0.push_back(e);
    go(0, 1'b1, 20, 32'd1);
    go(0, 1'b1, 20, 32'd0);

    e.sig = 32'd0; e.ones = '0; e.lat = 1;
    q0.push_back(e);
    go(0, 1'b1, 0, 32'h0000_1234);

    e = model(1'b1, 1000, 32'h0000_ACE1, 0, 16, 0);
    e.lat = 1001;
    q0.push_back(e);
    go(0, 1'b1, 1000, 32'h0000_ACE1);

    // Reset in the middle of an exhaustive run, then a clean rerun.
    @(negedge clk);
    ia.mode_i = 1'b0;
    ia.start_i = 1'b1;
    @(negedge clk);
    ia.start_i = 1'b0;
    for (int i = 0; i < 100 && x_a != 5'd10; i++) @(negedge clk);
    cmp("pre_reset_x", 80'(x_a), 80'd10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    @(negedge clk);
    cmp("midrun_reset_x", 80'(x_a), 80'd0);
    cmp("midrun_reset_busy", 80'(ia.busy_o), 80'd0);
    cmp("midrun_reset_signature", 80'(ia.signature_o), 80'd0);
    cmp("midrun_reset_ones", 80'(ia.ones_o), 80'd0);
    q0.push_back(e_id);
    go(0, 1'b0, 0, 32'd0);

    // start held high: three back-to-back runs, one IDLE cycle between them.
    chk_gap = 1'b1;
    repeat (3) q0.push_back(e_id);
    @(negedge clk);
    ia.mode_i = 1'b0;
    ia.start_i = 1'b1;
    k = 0;
    for (int i = 0; i < 300 && k < 3; i++) begin
      @(negedge clk);
      if (ia.done_o) k++;
    end
    ia.start_i = 1'b0;
    cmp("held_start_runs", 80'(k), 80'd3);
    repeat (4) @(negedge clk);
    cmp("held_start_stops", 80'(ia.busy_o), 80'd0);
    chk_gap = 1'b0;

    // Pipelined CUT: identical signature, three extra cycles.
    e = e_id;
    e.lat = 36;
    q1.push_back(e);
    go(1, 1'b0, 0, 32'd0);
    e = model(1'b1, 7, 32'hDEAD_BEEF, 0, 16, 3);
    q1.push_back(e);
    go(1, 1'b1, 7, 32'hDEAD_BEEF);

    // 4-bit ones counters saturate at 15.
    e = model(1'b0, 0, 32'd0, 2, 4, 0);
    e.ones = 80'hF_FFFF;
    q2.push_back(e);
    go(2, 1'b0, 0, 32'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
